// File: rtl/max_window.sv
// max_window: splits a valid-qualified stream into WIN-sample windows and emits each window's maximum and its index.
module max_window #(
   parameter int DW = 8,
   parameter int WIN = 16,
   parameter bit SIGNED = 1'b0,
   localparam int CW = (WIN > 1) ? $clog2(WIN) : 1
) (
   input  logic          clk,
   input  logic          master_rst,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   input  logic          frame_start,
   output logic [DW-1:0] max_out,
   output logic [CW-1:0] max_idx,
   output logic          max_valid,
   output logic          busy
);
   typedef enum logic {IDLE, ACC} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] count_q, count_d, run_idx_q, run_idx_d, max_idx_q, max_idx_d;
   logic [DW-1:0] run_max_q, run_max_d, max_out_q, max_out_d;
   logic max_valid_q, max_valid_d, gt, last, load;
   always_comb begin
      gt = SIGNED ? ($signed(din) > $signed(run_max_q)) : (din > run_max_q);
      last = count_q == CW'(WIN - 1);
      load = din_valid && (state_q == IDLE || frame_start);
      state_d = state_q;
      count_d = count_q;
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      max_out_d = max_out_q;
      max_idx_d = max_idx_q;
      max_valid_d = 1'b0;
      if (load) begin
         run_max_d = din;
         run_idx_d = '0;
         count_d = CW'(1);
         state_d = ACC;
         // a one-sample window completes on the very sample that opens it
         if (WIN == 1) begin
            max_out_d = din;
            max_idx_d = '0;
            max_valid_d = 1'b1;
            count_d = '0;
            state_d = IDLE;
         end
      end else if (frame_start) begin
         count_d = '0;
         state_d = IDLE;
      end else if (state_q == ACC && din_valid) begin
         run_max_d = gt ? din : run_max_q;
         run_idx_d = gt ? count_q : run_idx_q;
         count_d = count_q + CW'(1);
         if (last) begin
            max_out_d = run_max_d;
            max_idx_d = run_idx_d;
            max_valid_d = 1'b1;
            count_d = '0;
            state_d = IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (master_rst) begin
         state_q <= IDLE;
         count_q <= '0;
         run_max_q <= '0;
         run_idx_q <= '0;
         max_out_q <= '0;
         max_idx_q <= '0;
         max_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         run_max_q <= run_max_d;
         run_idx_q <= run_idx_d;
         max_out_q <= max_out_d;
         max_idx_q <= max_idx_d;
         max_valid_q <= max_valid_d;
      end
   end
   assign max_out = max_out_q;
   assign max_idx = max_idx_q;
   assign max_valid = max_valid_q;
   assign busy = state_q == ACC;
endmodule

// File: tb/tb_max_window.sv
// tb_max_window: directed vectors for WIN=4 unsigned/signed and WIN=1 instances.
module tb_max_window;
   logic clk = 1'b0, rst = 1'b1, v = 1'b0, fs = 1'b0;
   logic [7:0] d = '0;
   logic [7:0] mo0, mo1, mo2;
   logic [1:0] mi0, mi1;
   logic [0:0] mi2;
   logic mv0, mv1, mv2, b0, b1, b2;
   max_window #(.WIN(4)) u0 (.clk(clk), .master_rst(rst), .din(d), .din_valid(v), .frame_start(fs),
      .max_out(mo0), .max_idx(mi0), .max_valid(mv0), .busy(b0));
   max_window #(.WIN(4), .SIGNED(1'b1)) u1 (.clk(clk), .master_rst(rst), .din(d), .din_valid(v), .frame_start(fs),
      .max_out(mo1), .max_idx(mi1), .max_valid(mv1), .busy(b1));
   max_window #(.WIN(1)) u2 (.clk(clk), .master_rst(rst), .din(d), .din_valid(v), .frame_start(fs),
      .max_out(mo2), .max_idx(mi2), .max_valid(mv2), .busy(b2));
   always #5 clk = ~clk;
   typedef struct {
      logic r, v, f;
      logic [7:0] d;
      logic mv;
      logic [7:0] mx;
      logic [1:0] ix;
      logic b;
   } vec_t;
   vec_t q[$];
   int n_vec = 0, n_err = 0;
   task automatic add(input logic r, vv, ff, input logic [7:0] dd, input logic mv, input logic [7:0] mx,
                      input logic [1:0] ix, input logic b);
      vec_t t;
      t.r = r; t.v = vv; t.f = ff; t.d = dd; t.mv = mv; t.mx = mx; t.ix = ix; t.b = b;
      q.push_back(t);
   endtask
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask
   task automatic drive(input logic r, vv, ff, input logic [7:0] dd);
      @(negedge clk);
      rst = r; v = vv; fs = ff; d = dd;
      @(posedge clk);
      #1;
   endtask
   initial begin
      add(1,0,0,8'h00, 0,8'd0,2'd0,0);
      add(0,1,0,8'd3,  0,8'd0,2'd0,1);
      add(0,1,0,8'd9,  0,8'd0,2'd0,1);
      add(0,1,0,8'd9,  0,8'd0,2'd0,1);
      add(0,1,0,8'd2,  1,8'd9,2'd1,0);
      add(0,0,0,8'd0,  0,8'd9,2'd1,0);
      add(0,1,0,8'd5,  0,8'd9,2'd1,1);
      add(0,0,0,8'hAA, 0,8'd9,2'd1,1);
      add(0,0,0,8'hBB, 0,8'd9,2'd1,1);
      add(0,1,0,8'd7,  0,8'd9,2'd1,1);
      add(0,1,0,8'd1,  0,8'd9,2'd1,1);
      add(0,0,0,8'hCC, 0,8'd9,2'd1,1);
      add(0,1,0,8'd6,  1,8'd7,2'd1,0);
      add(0,0,0,8'd0,  0,8'd7,2'd1,0);
      add(0,1,0,8'd10, 0,8'd7,2'd1,1);
      add(0,1,0,8'd20, 0,8'd7,2'd1,1);
      add(0,1,1,8'd4,  0,8'd7,2'd1,1);
      add(0,1,0,8'd3,  0,8'd7,2'd1,1);
      add(0,1,0,8'd2,  0,8'd7,2'd1,1);
      add(0,1,0,8'd1,  1,8'd4,2'd0,0);
      add(0,1,0,8'd50, 0,8'd4,2'd0,1);
      add(0,1,0,8'd60, 0,8'd4,2'd0,1);
      add(0,1,0,8'd70, 0,8'd4,2'd0,1);
      add(1,0,0,8'd0,  0,8'd0,2'd0,0);
      add(0,1,0,8'd1,  0,8'd0,2'd0,1);
      add(0,1,0,8'd2,  0,8'd0,2'd0,1);
      add(0,1,0,8'd3,  0,8'd0,2'd0,1);
      add(0,1,0,8'd4,  1,8'd4,2'd3,0);
      add(0,1,0,8'd1,  0,8'd4,2'd3,1);
      add(0,1,0,8'd1,  0,8'd4,2'd3,1);
      add(0,1,0,8'd1,  0,8'd4,2'd3,1);
      add(0,1,1,8'd9,  0,8'd4,2'd3,1);
      add(0,1,0,8'd0,  0,8'd4,2'd3,1);
      add(0,1,0,8'd0,  0,8'd4,2'd3,1);
      add(0,1,0,8'd0,  1,8'd9,2'd0,0);
      add(0,1,0,8'd5,  0,8'd9,2'd0,1);
      add(0,0,1,8'd0,  0,8'd9,2'd0,0);
      add(0,1,0,8'd6,  0,8'd9,2'd0,1);
      add(0,1,0,8'd6,  0,8'd9,2'd0,1);
      add(0,1,0,8'd7,  0,8'd9,2'd0,1);
      add(0,1,0,8'd7,  1,8'd7,2'd2,0);
      add(0,0,0,8'd0,  0,8'd7,2'd2,0);
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i].r, q[i].v, q[i].f, q[i].d);
         chk($sformatf("vec%0d max_valid", i), 32'(mv0), 32'(q[i].mv));
         chk($sformatf("vec%0d max_out", i), 32'(mo0), 32'(q[i].mx));
         chk($sformatf("vec%0d max_idx", i), 32'(mi0), 32'(q[i].ix));
         chk($sformatf("vec%0d busy", i), 32'(b0), 32'(q[i].b));
      end
      drive(1, 0, 0, 8'h00);
      chk("signed reset max_out", 32'(mo1), 32'h0);
      drive(0, 1, 0, 8'h80);
      drive(0, 1, 0, 8'hFF);
      drive(0, 1, 0, 8'h7F);
      chk("signed busy mid", 32'(b1), 32'h1);
      drive(0, 1, 0, 8'h00);
      chk("signed max_valid", 32'(mv1), 32'h1);
      chk("signed max_out", 32'(mo1), 32'h7F);
      chk("signed max_idx", 32'(mi1), 32'h2);
      chk("unsigned max_out", 32'(mo0), 32'hFF);
      chk("unsigned max_idx", 32'(mi0), 32'h1);
      drive(0, 0, 0, 8'h00);
      chk("signed strobe drop", 32'(mv1), 32'h0);
      chk("signed hold", 32'(mo1), 32'h7F);
      drive(1, 0, 0, 8'h00);
      chk("win1 reset max_valid", 32'(mv2), 32'h0);
      drive(0, 1, 0, 8'd8);
      chk("win1 s0 valid", 32'(mv2), 32'h1);
      chk("win1 s0 max", 32'(mo2), 32'd8);
      chk("win1 s0 busy", 32'(b2), 32'h0);
      drive(0, 1, 0, 8'd3);
      chk("win1 s1 valid", 32'(mv2), 32'h1);
      chk("win1 s1 max", 32'(mo2), 32'd3);
      chk("win1 s1 idx", 32'(mi2), 32'h0);
      drive(0, 1, 0, 8'd5);
      chk("win1 s2 valid", 32'(mv2), 32'h1);
      chk("win1 s2 max", 32'(mo2), 32'd5);
      chk("win1 s2 busy", 32'(b2), 32'h0);
      drive(0, 0, 0, 8'd0);
      chk("win1 idle valid", 32'(mv2), 32'h0);
      chk("win1 idle hold", 32'(mo2), 32'd5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
